// File: rtl/operand_sequencer.sv
// Operand sequencer: walks a read-only operand table, unpacks each word into a/b and
// hands pairs downstream with valid/ready. Define OPSEQ_PAIR_CNT_EN to add the pair_cnt output.
module operand_sequencer #(
  parameter int unsigned OP_W   = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 6,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_mode,
  input  logic [2*OP_W-1:0]   douta,
  output logic [ADDR_W-1:0]   addra,
  output logic                en,
  output logic                wea,
  output logic [OP_W-1:0]     a,
  output logic [OP_W-1:0]     b,
  output logic                op_valid,
  input  logic                op_ready,
  output logic                busy,
  output logic                done
`ifdef OPSEQ_PAIR_CNT_EN
  ,
  output logic [15:0]         pair_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_VALID} state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [2:0]        LAT  = 3'(RD_LAT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [2:0]        wait_q, wait_d;
  logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic              loop_q, loop_d;
  logic              done_q, done_d;
  logic              accept_start, handshake;

  assign accept_start = (state_q == S_IDLE) && start && !stop;
  assign handshake    = (state_q == S_VALID) && op_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addra_d = addra_q;
    wait_d  = wait_q;
    a_d     = a_q;
    b_d     = b_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept_start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          loop_d  = loop_mode;
        end
      end
      S_FETCH: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          wait_d  = LAT;
        end
      end
      S_WAIT: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (wait_q == 3'd1) begin
          a_d     = douta[OP_W-1:0];
          b_d     = douta[2*OP_W-1:OP_W];
          state_d = S_VALID;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      S_VALID: begin
        if (op_ready) begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (!loop_q || stop) begin
              state_d = S_IDLE;
              done_d  = !loop_q && !stop;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = stop ? S_IDLE : S_FETCH;
          end
        end else if (stop) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // addra is registered, so it is loaded with the next counter on entry to FETCH
    if (state_d == S_FETCH) addra_d = cnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addra_q <= '0;
      wait_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addra_q <= addra_d;
      wait_q  <= wait_d;
      a_q     <= a_d;
      b_q     <= b_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
    end
  end

`ifdef OPSEQ_PAIR_CNT_EN
  logic [15:0] pair_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pair_cnt_q <= '0;
    else if (accept_start) pair_cnt_q <= '0;
    else if (handshake)    pair_cnt_q <= pair_cnt_q + 16'd1;
  end

  assign pair_cnt = pair_cnt_q;
`endif

  assign addra    = addra_q;
  assign en       = (state_q == S_FETCH) || (state_q == S_WAIT);
  assign wea      = 1'b0;
  assign a        = a_q;
  assign b        = b_q;
  assign op_valid = (state_q == S_VALID);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;

endmodule

// File: doc/operand_sequencer.md
Name: operand_sequencer

Overview:
- Parametrised successor to the fixed six-entry operand fetcher.
- Walks a read-only operand memory (BRAM, port A) and unpacks each word into operands a and b, then presents them to the multiplier datapath with a valid/ready handshake.
- Adds:
  - configurable operand width, table depth and read latency;
  - single-pass or looping mode;
  - explicit start/stop control with busy and done status.

Parameters:
- OP_W, 16: width of each operand; memory word is 2*OP_W.
- ADDR_W, 3: memory address width.
- DEPTH, 6: number of operand pairs in the table, 1..2^ADDR_W; entries live at addresses 0..DEPTH-1.
- RD_LAT, 1: memory read latency in cycles, 1..4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- stop  in  1  abort request; level-sampled every cycle.
- loop_mode  in  1  0 = single pass over table; 1 = wrap and repeat until stop. Sampled on start.
- douta  in  2*OP_W  memory read data.
- addra  out  ADDR_W  memory address (registered).
- en  out  1  memory enable.
- wea  out  1  memory write enable; constant 0.
- a  out  OP_W  operand A = douta[OP_W-1:0].
- b  out  OP_W  operand B = douta[2*OP_W-1:OP_W].
- op_valid  out  1  a/b hold a valid pair.
- op_ready  in  1  downstream accepts the pair when op_valid & op_ready.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a single-pass run completes.

Behaviour:

Reset (async assert, sync release):
- state = IDLE, addr counter = 0, addra = 0.
- a = 0, b = 0, op_valid = 0, busy = 0, done = 0.
- Reset mid-run discards everything; no done pulse.

States: IDLE, FETCH, WAIT, VALID.

IDLE:
- start & !stop -> FETCH, counter = 0, loop_mode latched.
- start & stop together -> remain IDLE.

FETCH (1 cycle):
- addra = counter, en = 1.
- Next state: WAIT, with the wait counter loaded to RD_LAT.

WAIT (RD_LAT cycles):
- en = 1.
- On the edge ending the last WAIT cycle: a <= douta[OP_W-1:0], b <= douta[2*OP_W-1:OP_W], then -> VALID.
- With RD_LAT = 1, douta during the single WAIT cycle equals mem[addra].

VALID:
- op_valid = 1; a and b held stable until handshake.
- On op_valid & op_ready:
  - counter == DEPTH-1 and loop_mode = 0 -> IDLE, done = 1 for exactly one cycle.
  - counter == DEPTH-1 and loop_mode = 1 -> counter = 0, FETCH.
  - otherwise counter + 1 -> FETCH.
- op_valid drops in the cycle after the handshake.

Timing:
- Minimum cadence with op_ready tied high is RD_LAT + 2 cycles per pair.
- First op_valid appears RD_LAT + 2 cycles after start is sampled.

Control signals:
- en = 1 only in FETCH and WAIT; 0 in IDLE and VALID.
- wea = 0 always.

stop:
- Stop in FETCH or WAIT -> IDLE next edge; a and b keep their last values; no done.
- Stop in VALID with handshake in the same cycle: the transfer counts, then -> IDLE with no done.
- Stop in VALID without handshake: op_valid drops next cycle -> IDLE.

Other rules:
- start while busy is ignored.
- Counter never exceeds DEPTH-1. No arithmetic overflow is possible; addra is zero-extended when DEPTH < 2^ADDR_W.
- DEPTH = 1: every pair reads address 0; in single-pass mode done follows the first handshake.

Optional Feature:
- Macro: OPSEQ_PAIR_CNT_EN.
- Defined:
  - Extra output port pair_cnt (out, 16 bits): count of completed handshakes since the last accepted start.
  - Cleared to 0 by reset and by an accepted start; wraps modulo 2^16; holds its value in IDLE.
- Undefined: port and counter logic absent; all other behaviour identical.

Test Plan:
- Reset values: rst_n low mid-run -> all outputs 0 immediately (asynchronously), state IDLE; run resumes only on a fresh start.
- Single pass, defaults, mem[k] = {16'(k+10), 16'(k+1)}, op_ready = 1: start -> six pairs with a = 1..6 and b = 10..15, one every 3 cycles, then done high for exactly 1 cycle with busy falling the same cycle.
- Backpressure: op_ready low 5 cycles while op_valid is high on pair 2 -> a, b and op_valid held stable; addra does not advance; pair 3 FETCH follows the cycle after op_ready rises.
- Loop mode, DEPTH = 4: addresses issued 0,1,2,3,0,1 without done; stop asserted in VALID without handshake -> op_valid 0 next cycle, busy 0, no done.
- RD_LAT = 2, OP_W = 8: first op_valid 4 cycles after start; a = douta[7:0] and b = douta[15:8] captured from the correct address; en high for 3 consecutive cycles per pair.
- With OPSEQ_PAIR_CNT_EN: two single-pass runs of DEPTH = 6 -> pair_cnt reads 6 after each run (cleared by the second start); start asserted while busy ignored and pair_cnt not cleared.
